// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus signal bundle for mem_access_unit.
// The unit connects through slave; the pipeline/memory side connects through master.
interface mem_access_unit_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFS = $clog2(NB);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-OFS-1:0] mem_addr;
    logic [NB-1:0]         mem_be;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_ack;
    logic [XLEN-1:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Sequential load/store unit: byte-lane alignment, load extension and
// splitting of word-crossing accesses into two req/ack memory beats.
module mem_access_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MISALIGN_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);
    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned AW  = ADDR_W - OFS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state, state_d;

    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [NB-1:0]    mem_be_q, mem_be_d;
    logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;

    // request decode (only meaningful while IDLE)
    logic [OFS-1:0]   off;
    int unsigned      len;
    logic [2*NB-1:0]  len_mask;
    logic [2*NB-1:0]  mask;
    logic [2*XLEN-1:0] wsh;
    logic             split;
    logic             err;

    // latched request
    logic [OFS-1:0]   lat_off;
    logic [1:0]       lat_size;
    logic             lat_uns;
    logic             lat_we;
    logic             lat_split;
    logic [NB-1:0]    lat_be_hi;
    logic [XLEN-1:0]  lat_wdata_hi;
    logic [XLEN-1:0]  rdata0;

    logic             accept;
    logic             capture;

    // Shift the beat pair down to the addressed byte, then sign/zero-extend.
    function automatic logic [XLEN-1:0] extend(
        input logic [2*XLEN-1:0] pair,
        input logic [OFS-1:0]    o,
        input logic [1:0]        sz,
        input logic              uns
    );
        logic [XLEN-1:0] v;
        logic [XLEN-1:0] res;
        int unsigned     nbits;
        logic            sb;
        v     = XLEN'(pair >> {o, 3'b000});
        nbits = 32'd8 << sz;
        case (sz)
            2'd0:    sb = v[7];
            2'd1:    sb = v[15];
            2'd2:    sb = v[31];
            default: sb = v[XLEN-1];
        endcase
        sb = sb & ~uns;
        for (int unsigned i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? v[i] : sb;
        end
        return res;
    endfunction

    always_comb begin
        off      = bus.req_addr[OFS-1:0];
        len      = 32'd1 << bus.req_size;
        len_mask = '0;
        for (int unsigned i = 0; i < 2 * NB; i++) begin
            len_mask[i] = (i < len);
        end
        mask  = len_mask << off;
        wsh   = {XLEN'(0), bus.req_wdata} << {off, 3'b000};
        split = (32'(off) + len) > NB;
        err   = (XLEN == 32 && bus.req_size == 2'd3) || (split && MISALIGN_EN == 0);
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d      = state;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = bus.req_addr[ADDR_W-1:OFS];
                        mem_be_d    = mask[NB-1:0];
                        mem_wdata_d = wsh[XLEN-1:0];
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ack) begin
                    capture = 1'b1;
                    if (lat_split) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + AW'(1);
                        mem_be_d    = lat_be_hi;
                        mem_wdata_d = lat_wdata_hi;
                    end else begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = '0;
                        mem_be_d     = '0;
                        mem_wdata_d  = '0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = lat_we ? '0
                                     : extend({XLEN'(0), bus.mem_rdata}, lat_off, lat_size, lat_uns);
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ack) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_be_d     = '0;
                    mem_wdata_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = lat_we ? '0
                                 : extend({bus.mem_rdata, rdata0}, lat_off, lat_size, lat_uns);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state        <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Request copy held for the whole access; beat0 read word kept for the merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_off      <= '0;
            lat_size     <= '0;
            lat_uns      <= 1'b0;
            lat_we       <= 1'b0;
            lat_split    <= 1'b0;
            lat_be_hi    <= '0;
            lat_wdata_hi <= '0;
            rdata0       <= '0;
        end else begin
            if (accept) begin
                lat_off      <= off;
                lat_size     <= bus.req_size;
                lat_uns      <= bus.req_unsigned;
                lat_we       <= bus.req_we;
                lat_split    <= split;
                lat_be_hi    <= mask[2*NB-1:NB];
                lat_wdata_hi <= wsh[2*XLEN-1:XLEN];
            end
            if (capture) begin
                rdata0 <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32): one split-enabled instance with a
// wait-state memory model, and one split-disabled instance for error responses.
module tb_mem_access_unit;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
    mem_access_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_nm ();

    mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN_EN(1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN_EN(0)) dut_nm (
        .clk(clk), .rst(rst), .bus(bus_nm.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [0:255];
    int          wait_states = 0;
    int          wait_cnt    = 0;
    int          nbeats      = 0;
    logic [29:0] beat_addr  [0:7];
    logic [3:0]  beat_be    [0:7];
    logic [31:0] beat_wdata [0:7];
    bit          nm_req_seen = 1'b0;

    // Memory model: ack after wait_states idle cycles of mem_req, log each beat.
    initial begin : responder
        logic [7:0] idx;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !rst) begin
                if (wait_cnt < wait_states) begin
                    wait_cnt++;
                end else begin
                    wait_cnt      = 0;
                    idx           = bus.mem_addr[7:0];
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[idx];
                    if (nbeats < 8) begin
                        beat_addr[nbeats]  = bus.mem_addr;
                        beat_be[nbeats]    = bus.mem_be;
                        beat_wdata[nbeats] = bus.mem_wdata;
                    end
                    nbeats++;
                    if (bus.mem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus.mem_be[b]) mem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        end
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (bus_nm.mem_req) nm_req_seen = 1'b1;
    end

    task automatic drive(input bit nm, input logic v, input logic we, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd);
        if (nm) begin
            bus_nm.req_valid = v; bus_nm.req_we = we; bus_nm.req_size = sz;
            bus_nm.req_unsigned = u; bus_nm.req_addr = a; bus_nm.req_wdata = wd;
        end else begin
            bus.req_valid = v; bus.req_we = we; bus.req_size = sz;
            bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
        end
    endtask

    function automatic logic get_rv(input bit nm);
        return nm ? bus_nm.resp_valid : bus.resp_valid;
    endfunction

    // Issue one request, scramble the inputs after accept, wait for the response.
    // lat counts cycles after the accept cycle until resp_valid is seen.
    task automatic run_req(input bit nm, input logic we, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        nbeats = 0;
        for (int i = 0; i < 8; i++) begin
            beat_addr[i] = '0; beat_be[i] = '0; beat_wdata[i] = '0;
        end
        check("req_ready_idle", nm ? bus_nm.req_ready : bus.req_ready, 1);
        drive(nm, 1'b1, we, sz, u, a, wd);
        @(negedge clk);
        drive(nm, 1'b0, ~we, 2'($urandom), ~u, $urandom, $urandom);
        lat = 1;
        while (!get_rv(nm) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("resp_valid_seen", get_rv(nm), 1);
        rd = nm ? bus_nm.resp_rdata : bus.resp_rdata;
        er = nm ? bus_nm.resp_err : bus.resp_err;
        @(negedge clk);
        check("resp_pulse_one_cycle", get_rv(nm), 0);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        bus_nm.mem_ack   = 1'b0;
        bus_nm.mem_rdata = '0;
        foreach (mem[i]) mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_mem_be", bus.mem_be, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        rst = 1'b0;

        // aligned lw, zero wait states
        mem[8'h40] = 32'hDEADBEEF;
        run_req(0, 0, 2'd2, 0, 32'h100, 0, rd, er, lat);
        check("t1_rdata", rd, 32'hDEADBEEF);
        check("t1_err", er, 0);
        check("t1_latency", lat, 2);
        check("t1_nbeats", nbeats, 1);
        check("t1_addr", beat_addr[0], 30'h40);
        check("t1_be", beat_be[0], 4'hF);

        // lb / lbu on top byte
        mem[8'h40] = 32'h80123456;
        run_req(0, 0, 2'd0, 0, 32'h103, 0, rd, er, lat);
        check("t2_lb_rdata", rd, 32'hFFFFFF80);
        check("t2_lb_be", beat_be[0], 4'b1000);
        run_req(0, 0, 2'd0, 1, 32'h103, 0, rd, er, lat);
        check("t2_lbu_rdata", rd, 32'h00000080);

        // split lw with 2 wait states per beat
        wait_states = 2;
        mem[8'h40] = 32'h11225566;
        mem[8'h41] = 32'h77883344;
        run_req(0, 0, 2'd2, 0, 32'h102, 0, rd, er, lat);
        check("t3_rdata", rd, 32'h33441122);
        check("t3_latency", lat, 7);
        check("t3_nbeats", nbeats, 2);
        check("t3_addr0", beat_addr[0], 30'h40);
        check("t3_be0", beat_be[0], 4'b1100);
        check("t3_addr1", beat_addr[1], 30'h41);
        check("t3_be1", beat_be[1], 4'b0011);

        // split sh
        wait_states = 0;
        run_req(0, 1, 2'd1, 0, 32'h103, 32'h0000ABCD, rd, er, lat);
        check("t4_rdata", rd, 0);
        check("t4_latency", lat, 3);
        check("t4_be0", beat_be[0], 4'b1000);
        check("t4_wdata0_b3", beat_wdata[0][31:24], 8'hCD);
        check("t4_be1", beat_be[1], 4'b0001);
        check("t4_wdata1_b0", beat_wdata[1][7:0], 8'hAB);
        check("t4_mem40", mem[8'h40], 32'hCD225566);
        check("t4_mem41", mem[8'h41], 32'h778833AB);

        // lh / lhu and sb
        run_req(0, 0, 2'd1, 0, 32'h102, 0, rd, er, lat);
        check("lh_rdata", rd, 32'hFFFFCD22);
        run_req(0, 0, 2'd1, 1, 32'h102, 0, rd, er, lat);
        check("lhu_rdata", rd, 32'h0000CD22);
        run_req(0, 1, 2'd0, 0, 32'h105, 32'h0000005A, rd, er, lat);
        check("sb_be", beat_be[0], 4'b0010);
        check("sb_wdata", beat_wdata[0][15:8], 8'h5A);
        check("sb_mem41", mem[8'h41], 32'h77885AAB);

        // error responses: size=3 on XLEN=32, misaligned with splitting disabled
        run_req(0, 0, 2'd3, 0, 32'h100, 0, rd, er, lat);
        check("t5_d_err", er, 1);
        check("t5_d_latency", lat, 1);
        check("t5_d_nbeats", nbeats, 0);
        check("t5_d_rdata", rd, 0);
        run_req(1, 1, 2'd2, 0, 32'h101, 32'h12345678, rd, er, lat);
        check("t5_nm_err", er, 1);
        check("t5_nm_latency", lat, 1);
        check("t5_nm_rdata", rd, 0);
        run_req(1, 0, 2'd3, 0, 32'h100, 0, rd, er, lat);
        check("t5_nm_d_err", er, 1);
        check("t5_nm_no_mem_req", nm_req_seen, 0);

        // reset while a beat waits for ack
        wait_states = 1000;
        @(negedge clk);
        drive(0, 1, 0, 2'd2, 0, 32'h100, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("t6_mem_req_pending", bus.mem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_mem_req_dropped", bus.mem_req, 0);
        check("t6_req_ready", bus.req_ready, 1);
        check("t6_resp_valid_rst", bus.resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_states = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_resp", bus.resp_valid, 0);
        end
        mem[8'h40] = 32'hDEADBEEF;
        run_req(0, 0, 2'd2, 0, 32'h100, 0, rd, er, lat);
        check("t6_rdata", rd, 32'hDEADBEEF);
        check("t6_latency", lat, 2);
        check("t6_be", beat_be[0], 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
